// File: rtl/piso_serializer_if.sv
// ============================================================================
//  Module   : piso_serializer_if
//  Purpose  : Parallel-word handshake and serial output bundle for the
//             piso_serializer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             so;
    logic             so_valid;
    logic             word_done;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  so,
        input  so_valid,
        input  word_done
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output so,
        output so_valid,
        output word_done
    );
endinterface

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : Parallel-in/serial-out serializer with a one-word holding
//             buffer so consecutive words stream without an idle gap.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic [WIDTH-1:0]   r_sh;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_load;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_out_bit;

    assign w_accept = bus.din_valid && !r_hold_full;
    assign w_last   = (r_state == c_SHIFT) && (r_cnt == c_LAST);
    // Reload either from idle or exactly on the last bit, giving gap-free streaming.
    assign w_load   = r_hold_full && ((r_state == c_IDLE) || w_last);

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_sh_next = {1'b0, r_sh[WIDTH-1:1]};
            assign w_out_bit = r_sh[0];
        end else begin : g_msb_first
            assign w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
            assign w_out_bit = r_sh[WIDTH-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_sh        <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_hold      <= bus.din;
                r_hold_full <= 1'b1;
            end

            if (w_load) begin
                r_sh        <= r_hold;
                r_cnt       <= '0;
                r_state     <= c_SHIFT;
                r_hold_full <= 1'b0;
            end else if (r_state == c_SHIFT) begin
                if (r_cnt != c_LAST) begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_state <= c_IDLE;
                end
            end
        end
    end

    assign bus.din_ready = !r_hold_full && !rst;
    assign bus.so        = (r_state == c_SHIFT) && w_out_bit;
    assign bus.so_valid  = (r_state == c_SHIFT);
    assign bus.word_done = w_last;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
//  Module   : tb_piso_serializer
//  Purpose  : Directed scoreboard bench for piso_serializer (8-bit LSB-first
//             and 5-bit MSB-first instances).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic done;
    } exp_t;

    logic clk;
    logic rst;

    piso_serializer_if #(.WIDTH(8)) bus_a ();
    piso_serializer_if #(.WIDTH(5)) bus_b ();

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    piso_serializer #(.WIDTH(5), .LSB_FIRST(1'b0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Expected bit order derived from the word and the transmit direction.
    task automatic push_word(input logic [31:0] w, input int width, input bit lsb_first);
        logic [31:0] wv;
        wv = w;
        for (int i = 0; i < width; i++) begin
            exp_t e;
            e.b    = lsb_first ? wv[i] : wv[width-1-i];
            e.done = (i == width - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_out(input string tag, input bit exp_valid,
                             input logic obs_valid, input logic obs_so, input logic obs_done);
        exp_t e;
        chk({tag, "_so_valid"}, 32'(obs_valid), 32'(exp_valid));
        if (exp_valid) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL %s_queue: observed empty scoreboard required pending bit", tag);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_so"}, 32'(obs_so), 32'(e.b));
                chk({tag, "_word_done"}, 32'(obs_done), 32'(e.done));
            end
        end else begin
            chk({tag, "_so_idle"}, 32'(obs_so), 32'd0);
            chk({tag, "_word_done_idle"}, 32'(obs_done), 32'd0);
        end
    endtask

    task automatic check_a(input string tag, input bit exp_valid);
        check_out(tag, exp_valid, bus_a.so_valid, bus_a.so, bus_a.word_done);
    endtask

    task automatic check_b(input string tag, input bit exp_valid);
        check_out(tag, exp_valid, bus_b.so_valid, bus_b.so, bus_b.word_done);
    endtask

    initial begin
        // Reset held with a word offered: nothing may be taken.
        rst             = 1'b1;
        bus_a.din       = 8'hFF;
        bus_a.din_valid = 1'b1;
        bus_b.din       = 5'h1F;
        bus_b.din_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_din_ready_a", 32'(bus_a.din_ready), 32'd0);
            chk("rst_din_ready_b", 32'(bus_b.din_ready), 32'd0);
            check_a("rst_a", 1'b0);
            check_b("rst_b", 1'b0);
        end
        bus_a.din_valid = 1'b0;
        bus_b.din_valid = 1'b0;
        rst             = 1'b0;
        #1;
        chk("post_rst_din_ready_a", 32'(bus_a.din_ready), 32'd1);
        chk("post_rst_din_ready_b", 32'(bus_b.din_ready), 32'd1);
        step();
        check_a("post_rst_a", 1'b0);
        check_b("post_rst_b", 1'b0);

        // Single word 8'hA5, LSB first.
        bus_a.din       = 8'hA5;
        bus_a.din_valid = 1'b1;
        step();
        bus_a.din_valid = 1'b0;
        chk("single_ready_after_accept", 32'(bus_a.din_ready), 32'd0);
        check_a("single_gap", 1'b0);
        push_word(32'hA5, 8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            check_a("single", 1'b1);
        end
        step();
        check_a("single_end", 1'b0);
        chk("single_queue_empty", 32'(exp_q.size()), 32'd0);

        // MSB-first 5-bit word 5'b10110.
        bus_b.din       = 5'b10110;
        bus_b.din_valid = 1'b1;
        step();
        bus_b.din_valid = 1'b0;
        check_b("msb_gap", 1'b0);
        push_word(32'h16, 5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_b("msb", 1'b1);
        end
        step();
        check_b("msb_end", 1'b0);
        chk("msb_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back 8'hA5 then 8'h3C with din_valid held high.
        bus_a.din       = 8'hA5;
        bus_a.din_valid = 1'b1;
        push_word(32'hA5, 8, 1'b1);
        step();                                   // edge k: accept A5
        chk("b2b_ready_k", 32'(bus_a.din_ready), 32'd0);
        check_a("b2b_gap", 1'b0);
        bus_a.din = 8'h3C;
        step();                                   // edge k+1: transfer A5
        chk("b2b_ready_k1", 32'(bus_a.din_ready), 32'd1);
        check_a("b2b", 1'b1);
        push_word(32'h3C, 8, 1'b1);
        step();                                   // edge k+2: accept 3C
        bus_a.din_valid = 1'b0;
        chk("b2b_ready_k2", 32'(bus_a.din_ready), 32'd0);
        check_a("b2b", 1'b1);
        for (int i = 3; i <= 8; i++) begin
            step();
            chk("b2b_ready_held", 32'(bus_a.din_ready), 32'd0);
            check_a("b2b", 1'b1);
        end
        for (int i = 9; i <= 16; i++) begin
            step();
            chk("b2b_ready_after_xfer", 32'(bus_a.din_ready), 32'd1);
            check_a("b2b", 1'b1);
        end
        step();
        check_a("b2b_end", 1'b0);
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-word: A5 shifting, 3C held, reset after the 3rd bit.
        bus_a.din       = 8'hA5;
        bus_a.din_valid = 1'b1;
        push_word(32'hA5, 8, 1'b1);
        step();
        bus_a.din = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) begin
                bus_a.din_valid = 1'b0;
                chk("midrst_3c_held", 32'(bus_a.din_ready), 32'd0);
                bus_a.din = 8'h81;                // changes while not ready
            end
            check_a("midrst", 1'b1);
        end
        rst = 1'b1;
        step();
        chk("midrst_ready_in_rst", 32'(bus_a.din_ready), 32'd0);
        check_a("midrst_rst", 1'b0);
        exp_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check_a("midrst_after", 1'b0);
        end

        // Starvation plus din toggled while not ready.
        bus_a.din       = 8'hFF;
        bus_a.din_valid = 1'b1;
        push_word(32'hFF, 8, 1'b1);
        step();                                   // accept FF
        chk("starve_ready_k", 32'(bus_a.din_ready), 32'd0);
        check_a("starve_gap", 1'b0);
        bus_a.din = 8'h00;                        // offered while not ready
        step();                                   // transfer FF, 00 ignored
        check_a("starve", 1'b1);
        bus_a.din_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus_a.din = 8'($urandom);
            step();
            check_a("starve", (i < 7));
        end
        chk("starve_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer with a one-word holding buffer. It sits directly upstream of the serial shift-register line and drives that line's serial input `si` from its `so` output. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock. Back-to-back words stream with no idle gap between them.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is WIDTH >= 2.
- `LSB_FIRST`, default 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `din`  in  WIDTH  parallel word; sampled only on an accepting edge.
- `din_valid`  in  1  `din` holds a word to send.
- `din_ready`  out  1  holding buffer can take a word.
- `so`  out  1  serial data; connects to the downstream `si`.
- `so_valid`  out  1  `so` carries a data bit this cycle.
- `word_done`  out  1  high while the last bit of a word is on `so`.

## Operation
- State:
  - holding register `hold` plus flag `hold_full`.
  - shift register `sh`.
  - bit counter `cnt`, width $clog2(WIDTH).
  - FSM with states IDLE and SHIFT.
- `din_ready = !hold_full && !rst`. It depends only on registered state; there is no combinational path from `din_valid`.
- Accept: when `din_valid && din_ready` at an edge, `hold <= din` and `hold_full <= 1`.
- Load condition (evaluated at each edge): `hold_full` AND (state == IDLE OR (state == SHIFT AND cnt == WIDTH-1)). When it holds:
  - `sh <= hold`, `cnt <= 0`, state <= SHIFT.
  - `hold_full <= 0`.
- Simultaneous accept and load cannot occur, because accept requires `!hold_full` and load requires `hold_full`.
- SHIFT, cnt < WIDTH-1: shift `sh` one position toward the output end and set `cnt <= cnt+1`.
- SHIFT, cnt == WIDTH-1, no load: state <= IDLE.
- Output bit:
  - LSB_FIRST=1: `so = sh[0]` and `sh` shifts right.
  - LSB_FIRST=0: `so = sh[WIDTH-1]` and `sh` shifts left.
  - Zeros fill the vacated end.
- `so_valid = (state == SHIFT)`.
- In IDLE, `so` is forced to 0.
- `word_done = (state == SHIFT) && (cnt == WIDTH-1)`.
- All outputs are registered or decoded from registers only; there are no combinational input-to-output paths except `rst` gating `din_ready`.

## Timing
- Reset values: `so=0`, `so_valid=0`, `word_done=0`, `din_ready=0` while `rst=1`.
  - After `rst` falls: `din_ready=1`, state IDLE, `hold_full=0`, `cnt=0`.
- Reset mid-operation: at the reset edge, the word in progress and any held word are discarded. Nothing resumes after reset.
- Latency: a word accepted at edge k is transferred at edge k+1. Bit i of the word appears on `so` after edge k+1+i, for i = 0..WIDTH-1.
- `word_done` is high in the cycle after edge k+WIDTH.
- Continuous streaming: if `hold_full` at the edge where cnt == WIDTH-1, the next word's first bit follows the previous word's last bit in the very next cycle. `so_valid` stays high throughout.
- Sustained throughput is one word per WIDTH cycles.
  - `din_ready` is high for exactly one cycle after each transfer.
  - `din_ready` is low from the accept edge until the next transfer edge.
- Starvation: with no held word at cnt == WIDTH-1, `so_valid` drops after the next edge and `so` reads 0 until the next load.
- `din` and `din_valid` are ignored on edges where `din_ready=0`. Changing `din` while `din_ready` is low has no effect.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `din_valid=1`.
  - Required: `so=0`, `so_valid=0`, `din_ready=0`, and no word accepted.
  - After `rst` falls: `din_ready=1`.
- Single word: WIDTH=8, LSB_FIRST=1, `din=8'hA5` accepted at edge k.
  - Required: `so` = 1,0,1,0,0,1,0,1 after edges k+1..k+8.
  - `so_valid` is high for exactly those 8 cycles.
  - `word_done` is high only after edge k+8.
  - `so=0` after edge k+9.
- Back-to-back: `din=8'hA5`, then `8'h3C`, with `din_valid` held high.
  - Required: 8'hA5 is accepted at k and 8'h3C at k+2.
  - `so` = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 over 16 contiguous cycles, with no gap in `so_valid`.
  - `din_ready` is low after edges k and k+2..k+8.
- MSB-first: WIDTH=5, LSB_FIRST=0, `din=5'b10110`.
  - Required: `so` = 1,0,1,1,0 on consecutive cycles, followed by `so_valid=0`.
- Reset mid-word: WIDTH=8, `8'hA5` shifting with `8'h3C` held; assert `rst` after the 3rd bit.
  - Required: after the reset edge, `so=0` and `so_valid=0`.
  - Neither remaining bits nor `8'h3C` ever appear.
- Starvation and ignored input: accept `8'hFF`, then hold `din_valid=0` for 12 cycles. Separately, toggle `din` while `din_ready=0`.
  - Required: 8 ones, then `so_valid=0` and `so=0`.
  - The toggled `din` values are never serialized.
